midi_sysex_patch_tx: RTL and testbench

//  Transmit side of the synth's MIDI SysEx patch path. On request, walks the synth parameter

---
 rtl/midi_sysex_patch_tx.sv | 262 ++++++++++++++++++++++++++
 tb/tb_midi_sysex_patch_tx.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_sysex_patch_tx.sv
// ----------------------------------------------------------------------------
// midi_sysex_patch_tx
//   Transmit side of the MIDI SysEx patch path. On dump_req the whole synth
//   parameter space (banks env, osc, m1, m2, com) is read over the controller
//   read bus. It is framed as one SysEx dump:
//     F0, MFR_ID, {0,midi_ch}, 12, {hi,lo nibble per parameter}..., CSUM, F7
//   and shifted out 8N1 at MIDI baud on midi_txd.
//
// Ports
//   CLOCK_50     in   system clock
//   reset_reg_N  in   asynchronous active-low reset
//   dump_req     in   one-cycle start pulse (only honoured while idle)
//   midi_ch      in   device id, sent as frame byte 3
//   busy         out  dump in progress, up to the end of the F7 stop bit
//   done         out  one-cycle pulse as busy falls
//   rd_err       out  sticky per dump: some read timed out
//   rd_req       out  read request, held until rd_valid or timeout
//   rd_sel       out  one-hot bank select {com,m2,m1,osc,env}, 0 when idle
//   rd_adr       out  parameter address within the bank
//   rd_data      in   parameter byte, sampled with rd_valid
//   rd_valid     in   one-cycle read acknowledge
//   midi_txd     out  serial MIDI output, idles high
// ----------------------------------------------------------------------------
module midi_sysex_patch_tx #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 31250,
    parameter logic [7:0]  MFR_ID     = 8'h7D,
    parameter int unsigned NUM_BANKS  = 5,
    parameter int unsigned BANK_LEN   = 128,
    parameter int unsigned RD_TIMEOUT = 64
) (
    input  logic       CLOCK_50,
    input  logic       reset_reg_N,
    input  logic       dump_req,
    input  logic [3:0] midi_ch,
    output logic       busy,
    output logic       done,
    output logic       rd_err,
    output logic       rd_req,
    output logic [4:0] rd_sel,
    output logic [6:0] rd_adr,
    input  logic [7:0] rd_data,
    input  logic       rd_valid,
    output logic       midi_txd
);

    localparam int unsigned DIV       = CLK_HZ / BAUD;
    localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
    localparam logic [15:0] TO_LAST   = 16'(RD_TIMEOUT - 1);
    localparam logic [6:0]  ADR_LAST  = 7'(BANK_LEN - 1);
    localparam logic [2:0]  BANK_LAST = 3'(NUM_BANKS - 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_HDR     = 4'd1;
    localparam logic [3:0] S_RDREQ   = 4'd2;
    localparam logic [3:0] S_RDWAIT  = 4'd3;
    localparam logic [3:0] S_SEND_HI = 4'd4;
    localparam logic [3:0] S_SEND_LO = 4'd5;
    localparam logic [3:0] S_CSUM    = 4'd6;
    localparam logic [3:0] S_EOX     = 4'd7;
    localparam logic [3:0] S_FIN     = 4'd8;

    logic [3:0]  state;
    logic [1:0]  hdr_idx;
    logic [3:0]  ch_q;
    logic [7:0]  data_q;
    logic [6:0]  csum;
    logic [15:0] to_cnt;
    logic [2:0]  bank;

    // serializer
    logic        ser_busy;
    logic [8:0]  ser_shift;
    logic [3:0]  bit_cnt;
    logic [15:0] baud_cnt;
    logic        ser_last;
    logic        ser_ready;

    // load strobe and byte presented by the FSM to the serializer
    logic        ld;
    logic [7:0]  ld_byte;
    logic [7:0]  hdr_byte;

    // The serializer counts as ready in the last cycle of a stop bit, so
    // a byte loaded then starts its start bit with no idle gap.
    assign ser_last  = ser_busy && (baud_cnt == '0) && (bit_cnt == '0);
    assign ser_ready = !ser_busy || ser_last;

    assign busy = (state != S_IDLE);

    always_comb begin
        hdr_byte = 8'hF0;
        case (hdr_idx)
            2'd0:    hdr_byte = 8'hF0;
            2'd1:    hdr_byte = MFR_ID;
            2'd2:    hdr_byte = {4'h0, ch_q};
            default: hdr_byte = 8'h12;
        endcase
    end

    always_comb begin
        ld      = 1'b0;
        ld_byte = '0;
        case (state)
            S_HDR: begin
                ld      = ser_ready;
                ld_byte = hdr_byte;
            end
            S_SEND_HI: begin
                ld      = ser_ready;
                ld_byte = {4'h0, data_q[7:4]};
            end
            S_SEND_LO: begin
                ld      = ser_ready;
                ld_byte = {4'h0, data_q[3:0]};
            end
            S_CSUM: begin
                ld      = ser_ready;
                ld_byte = {1'b0, 7'd0 - csum};
            end
            S_EOX: begin
                ld      = ser_ready;
                ld_byte = 8'hF7;
            end
            default: begin
                ld      = 1'b0;
                ld_byte = '0;
            end
        endcase
    end

    // 8N1 shifter: start bit driven on load, then 9 bit boundaries emit
    // d0..d7 and the stop bit (a 1 shifted in from the top).
    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            midi_txd  <= 1'b1;
            ser_busy  <= 1'b0;
            ser_shift <= '1;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
        end else if (ld) begin
            midi_txd  <= 1'b0;
            ser_busy  <= 1'b1;
            ser_shift <= {1'b1, ld_byte};
            bit_cnt   <= 4'd9;
            baud_cnt  <= DIV_LAST;
        end else if (ser_busy) begin
            if (baud_cnt != '0) begin
                baud_cnt <= baud_cnt - 16'd1;
            end else if (bit_cnt != '0) begin
                midi_txd  <= ser_shift[0];
                ser_shift <= {1'b1, ser_shift[8:1]};
                bit_cnt   <= bit_cnt - 4'd1;
                baud_cnt  <= DIV_LAST;
            end else begin
                ser_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state   <= S_IDLE;
            hdr_idx <= '0;
            ch_q    <= '0;
            data_q  <= '0;
            csum    <= '0;
            to_cnt  <= '0;
            bank    <= '0;
            rd_req  <= 1'b0;
            rd_sel  <= '0;
            rd_adr  <= '0;
            rd_err  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (dump_req) begin
                        state   <= S_HDR;
                        hdr_idx <= '0;
                        ch_q    <= midi_ch;
                        csum    <= '0;
                        bank    <= '0;
                        rd_sel  <= 5'b00001;
                        rd_adr  <= '0;
                        rd_err  <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (ld) begin
                        hdr_idx <= hdr_idx + 2'd1;
                        if (hdr_idx == 2'd3)
                            state <= S_RDREQ;
                    end
                end
                S_RDREQ: begin
                    rd_req <= 1'b1;
                    to_cnt <= '0;
                    state  <= S_RDWAIT;
                end
                S_RDWAIT: begin
                    if (rd_valid && rd_req) begin
                        data_q <= rd_data;
                        rd_req <= 1'b0;
                        state  <= S_SEND_HI;
                    end else if (to_cnt == TO_LAST) begin
                        // no acknowledge: send zero and flag it
                        data_q <= '0;
                        rd_err <= 1'b1;
                        rd_req <= 1'b0;
                        state  <= S_SEND_HI;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                S_SEND_HI: begin
                    if (ld) begin
                        csum  <= csum + {3'b000, data_q[7:4]};
                        state <= S_SEND_LO;
                    end
                end
                S_SEND_LO: begin
                    if (ld) begin
                        csum <= csum + {3'b000, data_q[3:0]};
                        if (rd_adr == ADR_LAST) begin
                            rd_adr <= '0;
                            if (bank == BANK_LAST) begin
                                rd_sel <= '0;
                                state  <= S_CSUM;
                            end else begin
                                bank   <= bank + 3'd1;
                                rd_sel <= {rd_sel[3:0], 1'b0};
                                state  <= S_RDREQ;
                            end
                        end else begin
                            rd_adr <= rd_adr + 7'd1;
                            state  <= S_RDREQ;
                        end
                    end
                end
                S_CSUM: begin
                    if (ld)
                        state <= S_EOX;
                end
                S_EOX: begin
                    if (ld)
                        state <= S_FIN;
                end
                S_FIN: begin
                    // wait for the F7 stop bit to finish on the wire
                    if (ser_last) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_midi_sysex_patch_tx.sv
module tb_midi_sysex_patch_tx;

    localparam int DIVB  = 16;
    localparam int NB    = 5;
    localparam int BL    = 3;
    localparam int NREAD = NB * BL;
    localparam int FLEN  = 6 + 2 * NREAD;

    logic       CLOCK_50    = 1'b0;
    logic       reset_reg_N = 1'b0;
    logic       dump_req    = 1'b0;
    logic [3:0] midi_ch     = 4'h0;
    logic       busy;
    logic       done;
    logic       rd_err;
    logic       rd_req;
    logic [4:0] rd_sel;
    logic [6:0] rd_adr;
    logic [7:0] rd_data     = 8'h00;
    logic       rd_valid    = 1'b0;
    logic       midi_txd;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [NREAD];
    bit         to_mask [NREAD];
    logic [7:0] exp_q [$];

    int read_idx    = 0;
    int mon_idx     = 0;
    int frames_seen = 0;
    int done_cnt    = 0;
    int done_exp    = 0;
    bit aborting    = 1'b0;
    bit any_to      = 1'b0;

    midi_sysex_patch_tx #(
        .CLK_HZ    (DIVB),
        .BAUD      (1),
        .MFR_ID    (8'h7D),
        .NUM_BANKS (NB),
        .BANK_LEN  (BL),
        .RD_TIMEOUT(64)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_reg_N(reset_reg_N),
        .dump_req   (dump_req),
        .midi_ch    (midi_ch),
        .busy       (busy),
        .done       (done),
        .rd_err     (rd_err),
        .rd_req     (rd_req),
        .rd_sel     (rd_sel),
        .rd_adr     (rd_adr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .midi_txd   (midi_txd)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference frame built straight from the frame rules.
    task automatic push_frame(input int ch);
        int sum;
        int d;
        sum = 0;
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h7D);
        exp_q.push_back(8'(ch));
        exp_q.push_back(8'h12);
        for (int i = 0; i < NREAD; i++) begin
            d = to_mask[i] ? 0 : int'(mem[i]);
            exp_q.push_back(8'(d / 16));
            exp_q.push_back(8'(d % 16));
            sum += d / 16 + d % 16;
        end
        exp_q.push_back(8'((128 - sum % 128) % 128));
        exp_q.push_back(8'hF7);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < NREAD; i++) begin
            mem[i]     = 8'($urandom);
            to_mask[i] = 1'b0;
        end
    endtask

    task automatic start_dump(input int ch, input bit full);
        any_to = 1'b0;
        for (int i = 0; i < NREAD; i++)
            if (to_mask[i]) any_to = 1'b1;
        read_idx = 0;
        midi_ch  = 4'(ch);
        push_frame(ch);
        if (full) done_exp++;
        @(negedge CLOCK_50);
        dump_req = 1'b1;
        @(negedge CLOCK_50);
        dump_req = 1'b0;
        check("busy_on_accept", busy, 1);
        check("rd_err_cleared", rd_err, 0);
        @(negedge CLOCK_50);
        check("start_bit_latency", midi_txd, 0);
    endtask

    task automatic wait_frame(input int target);
        int c;
        c = 0;
        while (frames_seen < target && c < 20000) begin
            @(negedge CLOCK_50);
            c++;
        end
        check("frame_complete", frames_seen >= target, 1);
    endtask

    // read-bus responder: checks the bank walk and answers from mem[]
    initial begin : responder
        int lat;
        int cnt;
        forever begin
            @(negedge CLOCK_50);
            if (rd_req === 1'b1 && !aborting) begin
                if (read_idx >= NREAD) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_read: got read %0d required at most %0d", read_idx + 1, NREAD);
                    cnt = 0;
                    while (rd_req === 1'b1 && cnt < 300) begin
                        @(negedge CLOCK_50);
                        cnt++;
                    end
                end else begin
                    check("rd_sel", rd_sel, 32'(1 << (read_idx / BL)));
                    check("rd_adr", rd_adr, 32'(read_idx % BL));
                    if (to_mask[read_idx]) begin
                        cnt = 0;
                        while (rd_req === 1'b1 && cnt < 300) begin
                            @(negedge CLOCK_50);
                            cnt++;
                        end
                        check("timeout_len", cnt, 64);
                    end else begin
                        lat = $urandom_range(0, 8);
                        repeat (lat) @(negedge CLOCK_50);
                        rd_valid = 1'b1;
                        rd_data  = mem[read_idx];
                        @(negedge CLOCK_50);
                        rd_valid = 1'b0;
                        rd_data  = 8'($urandom);
                        check("rd_req_drop", rd_req, 0);
                        // stray acknowledge while no request is pending
                        rd_valid = 1'b1;
                        @(negedge CLOCK_50);
                        rd_valid = 1'b0;
                    end
                    read_idx++;
                end
            end
        end
    end

    // line monitor: decodes 8N1 with per-cycle width checks, pops scoreboard
    initial begin : monitor
        logic [9:0] bits;
        logic [7:0] got;
        logic       glitch;
        logic       cut;
        logic       have;
        logic       last_busy;
        have = 1'b0;
        forever begin
            if (!have) @(negedge CLOCK_50);
            have = 1'b0;
            if (aborting) begin
                mon_idx = 0;
                continue;
            end
            if (midi_txd === 1'b0) begin
                glitch    = 1'b0;
                cut       = 1'b0;
                bits      = '0;
                last_busy = 1'b0;
                for (int k = 0; k < 10 * DIVB; k++) begin
                    if (k > 0) @(negedge CLOCK_50);
                    if (aborting) begin
                        cut = 1'b1;
                        break;
                    end
                    if (k % DIVB == 0) bits[k / DIVB] = midi_txd;
                    else if (midi_txd !== bits[k / DIVB]) glitch = 1'b1;
                    if (k == 10 * DIVB - 1) last_busy = busy;
                end
                if (cut) begin
                    mon_idx = 0;
                    continue;
                end
                got = bits[8:1];
                check("bit_width", glitch, 0);
                check("stop_bit", bits[9], 1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_byte: got %02h required no byte", got);
                end else begin
                    check($sformatf("byte%0d", mon_idx), got, exp_q.pop_front());
                end
                mon_idx++;
                if (mon_idx < FLEN) begin
                    @(negedge CLOCK_50);
                    have = 1'b1;
                    if (!aborting) check("no_gap", midi_txd, 0);
                end else begin
                    check("busy_through_f7", last_busy, 1);
                    @(negedge CLOCK_50);
                    check("done_pulse", done, 1);
                    check("busy_fall", busy, 0);
                    mon_idx = 0;
                    frames_seen++;
                end
            end
        end
    end

    always @(negedge CLOCK_50)
        if (done === 1'b1) done_cnt++;

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: got no end of run required end before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int c;
        int t;
        repeat (3) @(negedge CLOCK_50);
        check("rst_txd", midi_txd, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_err", rd_err, 0);
        check("rst_rd_req", rd_req, 0);
        check("rst_rd_sel", rd_sel, 0);
        check("rst_rd_adr", rd_adr, 0);
        reset_reg_N = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        // known nibble/checksum content up front
        fill_mem();
        mem[0] = 8'hA5;
        mem[1] = 8'h3C;
        start_dump(3, 1'b1);
        wait_frame(1);
        check("rd_err_clean", rd_err, 0);
        check("rd_sel_idle", rd_sel, 0);

        // timeouts on bank0 addr1 and bank2 addr1
        fill_mem();
        to_mask[1] = 1'b1;
        to_mask[7] = 1'b1;
        start_dump($urandom_range(0, 15), 1'b1);
        wait_frame(2);
        check("rd_err_sticky", rd_err, 1);

        // dump_req pulses during a frame must be ignored
        fill_mem();
        start_dump($urandom_range(0, 15), 1'b1);
        for (int p = 0; p < 5; p++) begin
            repeat ($urandom_range(100, 800)) @(negedge CLOCK_50);
            dump_req = 1'b1;
            @(negedge CLOCK_50);
            dump_req = 1'b0;
        end
        wait_frame(3);
        check("rd_err_after_clean", rd_err, 0);

        // reset during the start bit of frame byte 6
        fill_mem();
        start_dump($urandom_range(0, 15), 1'b0);
        c = 0;
        while (!(mon_idx == 6 && midi_txd === 1'b0) && c < 20000) begin
            @(negedge CLOCK_50);
            c++;
        end
        check("abort_sync", c < 20000, 1);
        repeat (3) @(negedge CLOCK_50);
        #2;
        aborting    = 1'b1;
        reset_reg_N = 1'b0;
        #1;
        check("abort_txd", midi_txd, 1);
        check("abort_busy", busy, 0);
        check("abort_rd_req", rd_req, 0);
        check("abort_rd_sel", rd_sel, 0);
        repeat (4) @(negedge CLOCK_50);
        exp_q.delete();
        read_idx    = 0;
        reset_reg_N = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        aborting = 1'b0;

        // complete frames after the abort, one with a random timeout
        fill_mem();
        t = $urandom_range(0, NREAD - 1);
        to_mask[t] = 1'b1;
        start_dump($urandom_range(0, 15), 1'b1);
        wait_frame(4);
        check("rd_err_random_to", rd_err, 32'(any_to));

        fill_mem();
        start_dump($urandom_range(0, 15), 1'b1);
        wait_frame(5);
        check("rd_err_final", rd_err, 0);

        repeat (20) @(negedge CLOCK_50);
        check("done_count", done_cnt, done_exp);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
